// File: rtl/ps2_key_event_receiver.sv
// PS/2 keyboard receiver: line synchroniser, 11-bit frame deserialiser, F0/E0 prefix
// decoder with scan-code-to-ASCII map, typematic repeat filter and event FIFO.
module ps2_key_event_receiver #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 8,
  parameter int FILTER_REPEAT  = 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        kb_clock,
  input  logic                        kb_data,
  input  logic                        ev_ready,
  output logic                        ev_valid,
  output logic [6:0]                  ev_ascii,
  output logic [7:0]                  ev_code,
  output logic                        ev_break,
  output logic                        ev_extended,
  output logic                        frame_error,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] ev_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

  logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
  logic                   clk_prev_q;
  logic                   clk_s, data_s, fall;

  state_e          state_q, state_d;
  logic [7:0]      shift_q, byte_q;
  logic [2:0]      bit_cnt_q;
  logic            parity_ok_q, byte_valid_q, reject_q;
  logic [TW-1:0]   timeout_q;
  logic            timeout_hit, shift_en, parity_en, deliver, reject;

  logic            break_pending_q, ext_pending_q;
  logic            last_valid_q, last_ext_q;
  logic [7:0]      last_code_q;
  logic            is_f0, is_e0, is_repeat, event_d, push;
  logic [6:0]      dec_ascii;
  logic [16:0]     push_entry;

  logic [16:0]     mem_q [FIFO_DEPTH];
  logic [16:0]     hold_q, head;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            overflow_q, full, empty, pop, push_ok;

  // Idle bus is high, so the synchroniser resets to 1 to avoid a false fall.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], kb_clock};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], kb_data};
      clk_prev_q  <= clk_s;
    end
  end

  assign clk_s       = clk_sync_q[SYNC_STAGES-1];
  assign data_s      = data_sync_q[SYNC_STAGES-1];
  assign fall        = clk_prev_q & ~clk_s;
  assign timeout_hit = (state_q != IDLE) && !fall && (timeout_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (fall && !data_s) state_d = DATA;
      DATA:   if (fall && bit_cnt_q == 3'd7) state_d = PARITY;
      PARITY: if (fall) state_d = STOP;
      STOP:   if (fall) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (timeout_hit) state_d = IDLE;
  end

  always_comb begin
    shift_en    = (state_q == DATA) && fall;
    parity_en   = (state_q == PARITY) && fall;
    deliver     = (state_q == STOP) && fall && parity_ok_q && data_s;
    reject      = (state_q == STOP) && fall && !(parity_ok_q && data_s);
    frame_error = timeout_hit | reject_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift_q      <= '0;
      byte_q       <= '0;
      bit_cnt_q    <= '0;
      parity_ok_q  <= 1'b0;
      byte_valid_q <= 1'b0;
      reject_q     <= 1'b0;
      timeout_q    <= '0;
    end else begin
      if (shift_en) shift_q <= {data_s, shift_q[7:1]};
      if (state_q == IDLE) bit_cnt_q <= '0;
      else if (shift_en)   bit_cnt_q <= bit_cnt_q + 3'd1;
      if (parity_en) parity_ok_q <= ^{shift_q, data_s};
      if (deliver)   byte_q <= shift_q;
      byte_valid_q <= deliver;
      reject_q     <= reject;
      if (state_q == IDLE || fall) timeout_q <= '0;
      else                         timeout_q <= timeout_q + TW'(1);
    end
  end

  function automatic logic [6:0] letter_ascii(input logic [7:0] c);
    case (c)
      8'h1C: letter_ascii = 7'd65;  8'h32: letter_ascii = 7'd66;
      8'h21: letter_ascii = 7'd67;  8'h23: letter_ascii = 7'd68;
      8'h24: letter_ascii = 7'd69;  8'h2B: letter_ascii = 7'd70;
      8'h34: letter_ascii = 7'd71;  8'h33: letter_ascii = 7'd72;
      8'h43: letter_ascii = 7'd73;  8'h3B: letter_ascii = 7'd74;
      8'h42: letter_ascii = 7'd75;  8'h4B: letter_ascii = 7'd76;
      8'h3A: letter_ascii = 7'd77;  8'h31: letter_ascii = 7'd78;
      8'h44: letter_ascii = 7'd79;  8'h4D: letter_ascii = 7'd80;
      8'h15: letter_ascii = 7'd81;  8'h2D: letter_ascii = 7'd82;
      8'h1B: letter_ascii = 7'd83;  8'h2C: letter_ascii = 7'd84;
      8'h3C: letter_ascii = 7'd85;  8'h2A: letter_ascii = 7'd86;
      8'h1D: letter_ascii = 7'd87;  8'h22: letter_ascii = 7'd88;
      8'h35: letter_ascii = 7'd89;  8'h1A: letter_ascii = 7'd90;
      default: letter_ascii = 7'd32;
    endcase
  endfunction

  assign is_f0      = (byte_q == 8'hF0);
  assign is_e0      = (byte_q == 8'hE0);
  assign dec_ascii  = ext_pending_q ? 7'd32 : letter_ascii(byte_q);
  assign event_d    = byte_valid_q && !is_f0 && !is_e0;
  assign is_repeat  = (FILTER_REPEAT != 0) && !break_pending_q && last_valid_q &&
                      (last_ext_q == ext_pending_q) && (last_code_q == byte_q);
  assign push       = event_d && !is_repeat;
  assign push_entry = {dec_ascii, byte_q, break_pending_q, ext_pending_q};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      break_pending_q <= 1'b0;
      ext_pending_q   <= 1'b0;
      last_valid_q    <= 1'b0;
      last_ext_q      <= 1'b0;
      last_code_q     <= '0;
    end else begin
      if (reject_q) begin
        break_pending_q <= 1'b0;
        ext_pending_q   <= 1'b0;
      end else if (byte_valid_q) begin
        if (is_f0)      break_pending_q <= 1'b1;
        else if (is_e0) ext_pending_q   <= 1'b1;
        else begin
          break_pending_q <= 1'b0;
          ext_pending_q   <= 1'b0;
        end
      end
      if (event_d && !break_pending_q && !is_repeat) begin
        last_valid_q <= 1'b1;
        last_ext_q   <= ext_pending_q;
        last_code_q  <= byte_q;
      end else if (event_d && break_pending_q && last_ext_q == ext_pending_q &&
                   last_code_q == byte_q) begin
        last_valid_q <= 1'b0;
      end
    end
  end

  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign pop     = !empty && ev_ready;
  assign push_ok = push && (!full || pop);

  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_entry;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      hold_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
        hold_q   <= mem_q[rd_ptr_q];
      end
      if (push_ok && !pop)      count_q <= count_q + CW'(1);
      else if (!push_ok && pop) count_q <= count_q - CW'(1);
      overflow_q <= push && full && !pop;
    end
  end

  // An empty queue keeps presenting the most recently consumed event.
  assign head     = empty ? hold_q : mem_q[rd_ptr_q];
  assign {ev_ascii, ev_code, ev_break, ev_extended} = head;
  assign ev_valid = !empty;
  assign ev_count = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_ps2_key_event_receiver.sv
// Directed bench for ps2_key_event_receiver: one filtering instance checked in detail,
// plus a non-filtering instance on the same bus whose event count is compared.
`timescale 1ns/1ps
module tb_ps2_key_event_receiver;
  localparam int S  = 2;
  localparam int T  = 200;
  localparam int D  = 4;
  localparam int CW = $clog2(D) + 1;

  logic clock = 1'b0, reset = 1'b1, kb_clock = 1'b1, kb_data = 1'b1, ev_ready = 1'b0;
  logic ev_valid, ev_break, ev_extended, frame_error, overflow;
  logic [6:0] ev_ascii;
  logic [7:0] ev_code;
  logic [CW-1:0] ev_count;
  logic nf_valid, nf_break, nf_extended, nf_frame_error, nf_overflow;
  logic [6:0] nf_ascii;
  logic [7:0] nf_code;
  logic [CW-1:0] nf_count;

  always #5 clock = ~clock;

  ps2_key_event_receiver #(.SYNC_STAGES(S), .TIMEOUT_CYCLES(T), .FIFO_DEPTH(D), .FILTER_REPEAT(1)) u_dut (
    .clock(clock), .reset(reset), .kb_clock(kb_clock), .kb_data(kb_data), .ev_ready(ev_ready),
    .ev_valid(ev_valid), .ev_ascii(ev_ascii), .ev_code(ev_code), .ev_break(ev_break),
    .ev_extended(ev_extended), .frame_error(frame_error), .overflow(overflow), .ev_count(ev_count));

  ps2_key_event_receiver #(.SYNC_STAGES(S), .TIMEOUT_CYCLES(T), .FIFO_DEPTH(D), .FILTER_REPEAT(0)) u_dut_nf (
    .clock(clock), .reset(reset), .kb_clock(kb_clock), .kb_data(kb_data), .ev_ready(1'b1),
    .ev_valid(nf_valid), .ev_ascii(nf_ascii), .ev_code(nf_code), .ev_break(nf_break),
    .ev_extended(nf_extended), .frame_error(nf_frame_error), .overflow(nf_overflow), .ev_count(nf_count));

  int n_vec = 0, n_bad = 0;
  int cyc = 0, fe_cnt = 0, ov_cnt = 0, nf_cnt = 0, sb_wr = 0, sb_rd = 0;
  int rise_cyc = -1, fall_cyc = 0;
  logic prev_v = 1'b0;
  logic [16:0] sb [0:63];

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (frame_error) fe_cnt <= fe_cnt + 1;
    if (overflow) ov_cnt <= ov_cnt + 1;
    if (nf_valid) nf_cnt <= nf_cnt + 1;
    if (ev_valid && ev_ready) begin
      sb[sb_wr[5:0]] <= {ev_ascii, ev_code, ev_break, ev_extended};
      sb_wr <= sb_wr + 1;
    end
  end

  always @(negedge clock) begin
    prev_v <= ev_valid;
    if (ev_valid && !prev_v && rise_cyc < 0) rise_cyc <= cyc;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_bit(input logic b, input bit pop_cycle);
    kb_data = b;
    tick(5);
    kb_clock = 1'b0;
    fall_cyc = cyc;
    if (pop_cycle) begin
      tick(S + 1);
      ev_ready = 1'b1;
      tick(1);
      ev_ready = 1'b0;
      tick(10 - S - 2);
    end else begin
      tick(10);
    end
    kb_clock = 1'b1;
    tick(5);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit pop_cycle);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0);
    send_bit((~^b) ^ bad_par, 1'b0);
    send_bit(1'b1, pop_cycle);
    tick(3);
    $display("frame 0x%02h%s sent at cycle %0d", b, bad_par ? " (bad parity)" : "", cyc);
  endtask

  function automatic int pk(input int a, input int c, input int brk, input int ext);
    return (a << 10) | (c << 2) | (brk << 1) | ext;
  endfunction

  task automatic expect_ev(input string tag, input int exp);
    check({tag, "_present"}, int'(sb_wr > sb_rd), 1);
    if (sb_wr > sb_rd) begin
      check(tag, int'(sb[sb_rd[5:0]]), exp);
      sb_rd++;
    end
  endtask

  initial begin
    int base, err_cyc, c0;
    tick(3);
    check("rst_valid", int'(ev_valid), 0);
    check("rst_count", int'(ev_count), 0);
    check("rst_ascii", int'(ev_ascii), 0);
    check("rst_code", int'(ev_code), 0);
    check("rst_ferr", int'(frame_error), 0);
    check("rst_ovf", int'(overflow), 0);
    reset = 1'b0;
    tick(3);

    // press and release A
    ev_ready = 1'b1;
    base = fe_cnt;
    send_frame(8'h1C, 0, 0);
    check("latency", rise_cyc - fall_cyc, S + 2);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h1C, 0, 0);
    expect_ev("a_make", pk(65, 8'h1C, 0, 0));
    expect_ev("a_break", pk(65, 8'h1C, 1, 0));
    check("no_ferr", fe_cnt - base, 0);

    // parity error then a good Q
    base = fe_cnt;
    send_frame(8'h1C, 1, 0);
    check("par_ferr", fe_cnt - base, 1);
    check("par_noev", sb_wr - sb_rd, 0);
    send_frame(8'h15, 0, 0);
    expect_ev("q_make", pk(81, 8'h15, 0, 0));

    // timeout after 4 data bits
    base = fe_cnt;
    send_bit(1'b0, 0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 0);
    kb_data = 1'b0;
    tick(5);
    kb_clock = 1'b0;
    c0 = cyc;
    tick(10);
    kb_clock = 1'b1;
    kb_data = 1'b1;
    err_cyc = -1;
    for (int i = 0; i < T + 50; i++) begin
      if (frame_error) begin
        err_cyc = cyc;
        break;
      end
      tick(1);
    end
    check("tmo_latency", err_cyc - c0, S + T);
    tick(5);
    check("tmo_ferr", fe_cnt - base, 1);
    send_frame(8'h1D, 0, 0);
    expect_ev("w_make", pk(87, 8'h1D, 0, 0));

    // extended make and break
    send_frame(8'hE0, 0, 0);
    send_frame(8'h75, 0, 0);
    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h75, 0, 0);
    expect_ev("ext_make", pk(32, 8'h75, 0, 1));
    expect_ev("ext_break", pk(32, 8'h75, 1, 1));

    // typematic repeat filter
    base = nf_cnt;
    send_frame(8'h2B, 0, 0);
    send_frame(8'h2B, 0, 0);
    send_frame(8'h2B, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h2B, 0, 0);
    send_frame(8'h2B, 0, 0);
    check("rep_count", sb_wr - sb_rd, 3);
    expect_ev("rep_make1", pk(70, 8'h2B, 0, 0));
    expect_ev("rep_break", pk(70, 8'h2B, 1, 0));
    expect_ev("rep_make2", pk(70, 8'h2B, 0, 0));
    check("nofilt_count", nf_cnt - base, 5);

    // fill, overflow, push-with-pop while full, drain
    ev_ready = 1'b0;
    base = ov_cnt;
    send_frame(8'h1C, 0, 0);
    send_frame(8'h32, 0, 0);
    send_frame(8'h21, 0, 0);
    send_frame(8'h23, 0, 0);
    send_frame(8'h24, 0, 0);
    check("full_count", int'(ev_count), D);
    check("full_ovf", ov_cnt - base, 1);
    check("full_valid", int'(ev_valid), 1);
    check("full_head", int'(ev_code), 8'h1C);
    send_frame(8'h2B, 0, 1);
    check("pushpop_count", int'(ev_count), D);
    check("pushpop_ovf", ov_cnt - base, 1);
    ev_ready = 1'b1;
    tick(10);
    check("drain_count", int'(ev_count), 0);
    check("drain_valid", int'(ev_valid), 0);
    check("hold_code", int'(ev_code), 8'h2B);
    check("hold_ascii", int'(ev_ascii), 70);
    expect_ev("fifo0", pk(65, 8'h1C, 0, 0));
    expect_ev("fifo1", pk(66, 8'h32, 0, 0));
    expect_ev("fifo2", pk(67, 8'h21, 0, 0));
    expect_ev("fifo3", pk(68, 8'h23, 0, 0));
    expect_ev("fifo4", pk(70, 8'h2B, 0, 0));
    check("fifo_extra", sb_wr - sb_rd, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got no completion expected finish before 5ms");
    $fatal(1);
  end

endmodule
